// File: rtl/trace_pkg.sv
// Shared types for the SLC-3 instruction-trace capture unit.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds its value between reads; only it is reset, not the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/slc3_trace_buffer.sv
// Instruction-trace capture unit: snapshots probe buses on each sample strobe,
// then replays them oldest-first once capture has ended.
module slc3_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         arm,
  input  logic                         wrap_en,
  input  logic                         sample,
  input  logic                         halt,
  input  logic [CHANNELS*WIDTH-1:0]    ch_data,
  input  logic                         rd_en,
  output logic [CHANNELS*WIDTH-1:0]    rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic [1:0]                   state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned DW = CHANNELS*WIDTH;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_FREE  = CW'(DEPTH-1);

  trace_state_t  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          wrap_q, wrap_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ram_we;
  logic          ram_re;

  // Arm wins over everything else in the same cycle, from any state.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wrap_d     = wrap_q;
    rd_valid_d = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    if (arm) begin
      state_d    = CAPTURE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      wrap_d     = wrap_en;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (sample) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            // Full only happens in wrap mode: the write lands on the oldest entry.
            if (count_q == FULL_COUNT) begin
              rd_ptr_d   = rd_ptr_q + AW'(1);
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
              if (!wrap_q && count_q == LAST_FREE) state_d = DONE;
            end
          end
          if (halt) state_d = DONE;
        end
        DONE: begin
          if (rd_en && count_q != '0) begin
            ram_re     = 1'b1;
            rd_ptr_d   = rd_ptr_q + AW'(1);
            count_d    = count_q - CW'(1);
            rd_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wrap_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wrap_q     <= wrap_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (ch_data),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule
